// File: rtl/wb_mem_responder.sv
//------------------------------------------------------------------------------
// wb_mem_responder
// Wishbone classic single-beat memory responder with byte-maskable word array,
// programmable wait states and ack/err/rty terminations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_mem_responder #(
  parameter int                  XLEN        = 64,
  parameter int                  ADDR_LEN    = 32,
  parameter int                  DEPTH_LOG2  = 8,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR   = '0,
  parameter int                  WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_LEN-1:0] wb_adr_i,
  input  logic [XLEN-1:0]     wb_dat_i,
  input  logic [XLEN/8-1:0]   wb_sel_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [1:0]          wb_bte_i,
  input  logic                stall_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [XLEN-1:0]     wb_dat_o
);

  localparam int         BYTES    = XLEN / 8;
  localparam int         OFFS     = $clog2(BYTES);
  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic                    lat_we;
  logic [BYTES-1:0]        lat_sel;
  logic [XLEN-1:0]         lat_dat;
  logic [XLEN-1:0]         mem [DEPTH];

  logic                    req;
  logic [ADDR_LEN-1:0]     offset;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic                    acc_we;
  logic [BYTES-1:0]        acc_sel;
  logic [XLEN-1:0]         acc_dat;
  logic                    do_access;
  logic                    unused_ok;

  assign req    = wb_cyc_i & wb_stb_i;
  assign offset = wb_adr_i - BASE_ADDR;
  // A wrapped subtraction shows up as adr < BASE_ADDR, hence the explicit compare.
  assign in_range = (wb_adr_i >= BASE_ADDR) &&
                    (offset[ADDR_LEN-1:OFFS+DEPTH_LOG2] == '0);

  assign unused_ok = ^{wb_cti_i, wb_bte_i, offset[OFFS-1:0]};

  // Zero-wait accesses use the live bus; delayed ones use the latched request.
  always_comb begin
    acc_idx = lat_idx;
    acc_we  = lat_we;
    acc_sel = lat_sel;
    acc_dat = lat_dat;
    if (state == IDLE) begin
      acc_idx = offset[OFFS+DEPTH_LOG2-1:OFFS];
      acc_we  = wb_we_i;
      acc_sel = wb_sel_i;
      acc_dat = wb_dat_i;
    end
  end

  assign do_access = !rst &&
                     (((state == IDLE) && req && in_range && !stall_i && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && wb_cyc_i && (cnt == 4'd0)));

  always_ff @(posedge clk) begin
    if (do_access && acc_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (acc_sel[b]) mem[acc_idx][b*8 +: 8] <= acc_dat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_idx  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_dat  <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      if (do_access) begin
        wb_ack_o <= 1'b1;
        if (!acc_we) wb_dat_o <= mem[acc_idx];
        state <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              lat_idx <= offset[OFFS+DEPTH_LOG2-1:OFFS];
              lat_we  <= wb_we_i;
              lat_sel <= wb_sel_i;
              lat_dat <= wb_dat_i;
              if (!in_range) begin
                wb_err_o <= 1'b1;
                state    <= RESP;
              end else if (stall_i) begin
                wb_rty_o <= 1'b1;
                state    <= RESP;
              end else begin
                cnt   <= CNT_INIT;
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (!wb_cyc_i) state <= IDLE;
            else           cnt   <= cnt - 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
